gg_vga_scaler: RTL and testbench

- Pixel source for the VGA timing stage. Reads the 160x144 Game Gear frame from the framebuffer RAM and triple-scales it to 480x432, centred in the 640x480 raster.
- Drives vga_r/g/b for each coordinate the timing stage reports. Outside the scaled window it drives the border colour.
- Prefetches each source row into an on-chip line buffer during the preceding horizontal blank.

---
 rtl/gg_video_pkg.sv | 30 +++
 rtl/gg_line_ram.sv | 23 ++
 rtl/gg_vga_scaler.sv | 209 ++++++++++++++++++++
 tb/tb_gg_vga_scaler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gg_video_pkg.sv
// Shared Game Gear video constants, the 12-bit pixel type and the row-fetch FSM states.
package gg_video_pkg;

  localparam int SRC_W    = 160;
  localparam int SRC_H    = 144;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int COL_W  = $clog2(SRC_W + 1);
  localparam int ROW_W  = $clog2(SRC_H);
  localparam int ADDR_W = 15;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } fetch_state_e;

  function automatic rgb12_t halve_rgb(input rgb12_t c);
    halve_rgb = {1'b0, c.r[3:1], 1'b0, c.g[3:1], 1'b0, c.b[3:1]};
  endfunction

endpackage

// File: rtl/gg_line_ram.sv
// One source row of pixels: synchronous write port, asynchronous read port.
module gg_line_ram
  import gg_video_pkg::*;
(
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [COL_W-1:0] waddr_i,
  input  rgb12_t           wdata_i,
  input  logic [COL_W-1:0] raddr_i,
  output rgb12_t           rdata_o
);

  rgb12_t mem_q [SRC_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/gg_vga_scaler.sv
// Triple-scales the 160x144 Game Gear frame into the 640x480 VGA raster via a one-row line buffer.
// Optional scanline dimming on the last replicated line is enabled by defining GG_SCALER_SCANLINE_EN.
module gg_vga_scaler
  import gg_video_pkg::*;
#(
  parameter int          SCALE      = 3,
  parameter int          X_OFS      = 80,
  parameter int          Y_OFS      = 24,
  parameter logic [11:0] BORDER_RGB = 12'h000
) (
  input  logic              clk_50_i,
  input  logic              rst_i,
  input  logic              pixel_en_i,
  input  logic [9:0]        pixel_x_i,
  input  logic [9:0]        pixel_y_i,
  input  logic              active_i,
  output logic              fb_rd_o,
  output logic [ADDR_W-1:0] fb_addr_o,
  input  logic [11:0]       fb_data_i,
  output logic [3:0]        vga_r_o,
  output logic [3:0]        vga_g_o,
  output logic [3:0]        vga_b_o,
  output logic              underrun_o
);

  localparam int WIN_W = SRC_W * SCALE;
  localparam int WIN_H = SRC_H * SCALE;
  localparam int PH_W  = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SCALE - 1);

  fetch_state_e      state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  srcRow_q;
  logic [ADDR_W-1:0] rowBase_q;
  logic [PH_W-1:0]   linePh_q, linePhNext;
  logic              armed_q;
  logic              underrun_q;
  logic [COL_W-1:0]  srcCol_q, curCol;
  logic [PH_W-1:0]   subPh_q, curPh;
  rgb12_t            rgb_q, rgb_d;

  logic              frameStart, hEnd, trigger, nextInRange;
  logic [10:0]       nextLine;
  logic              inWinX, inWinY;
  logic              lineWe;
  logic [COL_W-1:0]  lineWaddr;
  rgb12_t            lineRdata, pix;

  assign frameStart  = pixel_en_i && (pixel_x_i == 10'd0) && (pixel_y_i == 10'd0);
  assign hEnd        = pixel_en_i && (pixel_x_i == 10'(H_ACTIVE));
  assign nextLine    = {1'b0, pixel_y_i} + 11'd1;
  assign nextInRange = (nextLine >= 11'(Y_OFS)) && (nextLine < 11'(Y_OFS + WIN_H));

  // Line phase of the upcoming line; phase 0 marks the first copy of a new source row.
  always_comb begin
    linePhNext = linePh_q + PH_W'(1);
    if ((nextLine == 11'(Y_OFS)) || (linePh_q == PH_LAST)) begin
      linePhNext = '0;
    end
  end

  assign trigger = hEnd && nextInRange && (linePhNext == '0);

  always_ff @(posedge clk_50_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    unique case (state_q)
      ST_IDLE: begin
        col_d = '0;
        if (trigger) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        col_d = col_q + COL_W'(1);
        if (col_q == COL_W'(SRC_W - 1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign fb_rd_o   = (state_q == ST_FETCH);
  assign fb_addr_o = fb_rd_o ? (rowBase_q + ADDR_W'(col_q)) : '0;

  // Read data lands one cycle after its strobe, so the write index trails col by one.
  assign lineWe    = ((state_q == ST_FETCH) && (col_q != '0)) || (state_q == ST_DRAIN);
  assign lineWaddr = col_q - COL_W'(1);

  always_ff @(posedge clk_50_i) begin
    if (rst_i) begin
      srcRow_q   <= '0;
      rowBase_q  <= '0;
      linePh_q   <= '0;
      armed_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (frameStart) begin
        srcRow_q  <= '0;
        rowBase_q <= '0;
        linePh_q  <= '0;
        armed_q   <= 1'b0;
      end else begin
        if ((state_q == ST_DONE) && (srcRow_q != ROW_W'(SRC_H - 1))) begin
          srcRow_q  <= srcRow_q + ROW_W'(1);
          rowBase_q <= rowBase_q + ADDR_W'(SRC_W);
        end
        if (hEnd && nextInRange) begin
          linePh_q <= linePhNext;
        end
        if (pixel_en_i && active_i && armed_q) begin
          armed_q <= 1'b0;
        end
        if (trigger && (state_q == ST_IDLE)) begin
          armed_q <= 1'b1;
        end
      end
      if (trigger && (state_q != ST_IDLE)) begin
        underrun_q <= 1'b1;
      end
      if (pixel_en_i && active_i && armed_q &&
          ((state_q == ST_FETCH) || (state_q == ST_DRAIN))) begin
        underrun_q <= 1'b1;
      end
    end
  end

  assign inWinX = (pixel_x_i >= 10'(X_OFS)) && (pixel_x_i < 10'(X_OFS + WIN_W));
  assign inWinY = (pixel_y_i >= 10'(Y_OFS)) && (pixel_y_i < 10'(Y_OFS + WIN_H));

  always_comb begin
    curCol = srcCol_q;
    curPh  = subPh_q;
    if (pixel_x_i == 10'(X_OFS)) begin
      curCol = '0;
      curPh  = '0;
    end
  end

  always_ff @(posedge clk_50_i) begin
    if (rst_i) begin
      srcCol_q <= '0;
      subPh_q  <= '0;
    end else if (pixel_en_i && inWinX) begin
      if (curPh == PH_LAST) begin
        subPh_q  <= '0;
        srcCol_q <= curCol + COL_W'(1);
      end else begin
        subPh_q  <= curPh + PH_W'(1);
        srcCol_q <= curCol;
      end
    end
  end

  gg_line_ram u_line_ram (
    .clk_i   (clk_50_i),
    .we_i    (lineWe),
    .waddr_i (lineWaddr),
    .wdata_i (fb_data_i),
    .raddr_i (curCol),
    .rdata_o (lineRdata)
  );

  always_comb begin
    pix = lineRdata;
`ifdef GG_SCALER_SCANLINE_EN
    if (linePh_q == PH_LAST) begin
      pix = halve_rgb(lineRdata);
    end
`endif
    rgb_d = rgb_q;
    if (pixel_en_i) begin
      if (!active_i) begin
        rgb_d = '0;
      end else if (inWinX && inWinY) begin
        rgb_d = pix;
      end else begin
        rgb_d = BORDER_RGB;
      end
    end
  end

  always_ff @(posedge clk_50_i) begin
    if (rst_i) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign vga_r_o    = rgb_q.r;
  assign vga_g_o    = rgb_q.g;
  assign vga_b_o    = rgb_q.b;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_gg_vga_scaler.sv
// Self-checking bench for gg_vga_scaler: random framebuffer contents against a divide-based pixel model.
module tb_gg_vga_scaler;

  localparam logic [11:0] BORDER = 12'hF0F;
`ifdef GG_SCALER_SCANLINE_EN
  localparam logic [11:0] LINE26 = 12'h777;
`else
  localparam logic [11:0] LINE26 = 12'hEEE;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pixelEn = 1'b0;
  logic        active = 1'b0;
  logic [9:0]  pixelX = '0;
  logic [9:0]  pixelY = '0;
  logic        fbRd;
  logic [14:0] fbAddr;
  logic [11:0] fbData;
  logic [3:0]  vgaR, vgaG, vgaB;
  logic        underrun;

  logic [11:0] fbMem [0:23039];
  logic [14:0] rdLog [0:4095];
  int          rdCount;
  int          checks = 0;
  int          passes = 0;

  gg_vga_scaler #(.BORDER_RGB(BORDER)) dut (
    .clk_50_i   (clk),
    .rst_i      (rst),
    .pixel_en_i (pixelEn),
    .pixel_x_i  (pixelX),
    .pixel_y_i  (pixelY),
    .active_i   (active),
    .fb_rd_o    (fbRd),
    .fb_addr_o  (fbAddr),
    .fb_data_i  (fbData),
    .vga_r_o    (vgaR),
    .vga_g_o    (vgaG),
    .vga_b_o    (vgaB),
    .underrun_o (underrun)
  );

  always #10 clk = ~clk;

  // Framebuffer model: data appears one clock after the read strobe; every read is logged.
  always @(posedge clk) begin
    if (fbRd) begin
      fbData <= fbMem[fbAddr];
      rdLog[rdCount % 4096] <= fbAddr;
      rdCount <= rdCount + 1;
    end else begin
      fbData <= 12'h000;
    end
  end

  function automatic logic [11:0] modelPix(input int x, input int y, input bit act);
    logic [11:0] v;
    if (!act) return 12'h000;
    if (x >= 80 && x < 560 && y >= 24 && y < 456) begin
      v = fbMem[((y - 24) / 3) * 160 + (x - 80) / 3];
`ifdef GG_SCALER_SCANLINE_EN
      if ((y - 24) % 3 == 2) v = {1'b0, v[11:9], 1'b0, v[7:5], 1'b0, v[3:1]};
`endif
      return v;
    end
    return BORDER;
  endfunction

  task automatic strobe(input int x, input int y, input bit act);
    pixelEn = 1'b1;
    pixelX  = 10'(x);
    pixelY  = 10'(y);
    active  = act;
    @(posedge clk); #1;
    pixelEn = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic fillRandom();
    for (int a = 0; a < 23040; a++) fbMem[a] = 12'($urandom);
  endtask

  task automatic runLine(input int y);
    logic [11:0] exp, got;
    bit act;
    for (int x = 0; x < 800; x++) begin
      act = (x < 640) && (y < 480);
      strobe(x, y, act);
      exp = modelPix(x, y, act);
      got = {vgaR, vgaG, vgaB};
      checks++;
      if (got !== exp) $display("[TB] FAIL pixel(%0d,%0d): got %h expected %h", x, y, got, exp);
      else passes++;
    end
  endtask

  task automatic runFrame(input int lastLine);
    logic [11:0] got;
    strobe(0, 0, 1'b1);
    got = {vgaR, vgaG, vgaB};
    checks++;
    if (got !== BORDER) $display("[TB] FAIL frame_start_pixel: got %h expected %h", got, BORDER);
    else passes++;
    for (int y = 23; y <= lastLine; y++) runLine(y);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (fbRd !== 1'b0) $display("[TB] FAIL reset_fb_rd: got %b expected 0", fbRd); else passes++;
    checks++; if (fbAddr !== 15'd0) $display("[TB] FAIL reset_fb_addr: got %0d expected 0", fbAddr); else passes++;
    checks++; if ({vgaR, vgaG, vgaB} !== 12'h000) $display("[TB] FAIL reset_rgb: got %h expected 000", {vgaR, vgaG, vgaB}); else passes++;
    checks++; if (underrun !== 1'b0) $display("[TB] FAIL reset_underrun: got %b expected 0", underrun); else passes++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch();
    int base, cycles;
    fillRandom();
    strobe(0, 0, 1'b1);
    base = rdCount;
    pixelEn = 1'b1; pixelX = 10'd640; pixelY = 10'd23; active = 1'b0;
    @(posedge clk); #1;
    pixelEn = 1'b0;
    cycles = 0;
    while (!((rdCount - base) == 160 && fbRd == 1'b0) && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
    checks++; if (cycles > 163) $display("[TB] FAIL fetch_duration: got %0d cycles expected <=163", cycles); else passes++;
    checks++; if ((rdCount - base) != 160) $display("[TB] FAIL fetch_count: got %0d expected 160", rdCount - base); else passes++;
    for (int i = 0; i < 160; i++) begin
      checks++;
      if (rdLog[(base + i) % 4096] !== 15'(i))
        $display("[TB] FAIL fetch_addr[%0d]: got %0d expected %0d", i, rdLog[(base + i) % 4096], i);
      else passes++;
    end
    if (cycles < 162) repeat (162 - cycles) @(posedge clk);
    #1;
    strobe(640, 23, 1'b0);
    checks++; if (underrun !== 1'b0) $display("[TB] FAIL fetch_underrun: got %b expected 0", underrun); else passes++;
    repeat (200) @(posedge clk);
    #1;
    checks++; if ((rdCount - base) != 320) $display("[TB] FAIL fetch2_count: got %0d expected 320", rdCount - base); else passes++;
    checks++; if (rdLog[(base + 160) % 4096] !== 15'd160) $display("[TB] FAIL fetch2_first: got %0d expected 160", rdLog[(base + 160) % 4096]); else passes++;
    checks++; if (rdLog[(base + 319) % 4096] !== 15'd319) $display("[TB] FAIL fetch2_last: got %0d expected 319", rdLog[(base + 319) % 4096]); else passes++;
  endtask

  task automatic test_frame();
    fillRandom();
    runFrame(30);
    checks++; if (underrun !== 1'b0) $display("[TB] FAIL frame_underrun: got %b expected 0", underrun); else passes++;
  endtask

  task automatic test_border();
    strobe(10, 10, 1'b1);
    checks++; if ({vgaR, vgaG, vgaB} !== BORDER) $display("[TB] FAIL border_10_10: got %h expected %h", {vgaR, vgaG, vgaB}, BORDER); else passes++;
    strobe(10, 10, 1'b0);
    checks++; if ({vgaR, vgaG, vgaB} !== 12'h000) $display("[TB] FAIL blank_10_10: got %h expected 000", {vgaR, vgaG, vgaB}); else passes++;
    strobe(300, 100, 1'b0);
    checks++; if ({vgaR, vgaG, vgaB} !== 12'h000) $display("[TB] FAIL blank_in_window: got %h expected 000", {vgaR, vgaG, vgaB}); else passes++;
    strobe(300, 10, 1'b1);
    checks++; if ({vgaR, vgaG, vgaB} !== BORDER) $display("[TB] FAIL border_above_window: got %h expected %h", {vgaR, vgaG, vgaB}, BORDER); else passes++;
    repeat (5) @(posedge clk);
    #1;
    checks++; if ({vgaR, vgaG, vgaB} !== BORDER) $display("[TB] FAIL hold_between_strobes: got %h expected %h", {vgaR, vgaG, vgaB}, BORDER); else passes++;
  endtask

  task automatic test_reset_mid_fetch();
    int base, waitCycles, held;
    fillRandom();
    strobe(0, 0, 1'b1);
    base = rdCount;
    pixelEn = 1'b1; pixelX = 10'd640; pixelY = 10'd23; active = 1'b0;
    @(posedge clk); #1;
    pixelEn = 1'b0;
    waitCycles = 0;
    while ((rdCount - base) < 50 && waitCycles < 100) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    checks++; if ((rdCount - base) < 50) $display("[TB] FAIL midfetch_reach_col50: got %0d reads expected 50", rdCount - base); else passes++;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (fbRd !== 1'b0) $display("[TB] FAIL midfetch_fb_rd: got %b expected 0", fbRd); else passes++;
    checks++; if (fbAddr !== 15'd0) $display("[TB] FAIL midfetch_fb_addr: got %0d expected 0", fbAddr); else passes++;
    checks++; if ({vgaR, vgaG, vgaB} !== 12'h000) $display("[TB] FAIL midfetch_rgb: got %h expected 000", {vgaR, vgaG, vgaB}); else passes++;
    checks++; if (underrun !== 1'b0) $display("[TB] FAIL midfetch_underrun: got %b expected 0", underrun); else passes++;
    rst = 1'b0;
    held = rdCount;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (rdCount != held) $display("[TB] FAIL midfetch_no_reads: got %0d reads expected 0", rdCount - held); else passes++;
    runFrame(26);
    checks++; if (underrun !== 1'b0) $display("[TB] FAIL midfetch_next_underrun: got %b expected 0", underrun); else passes++;
  endtask

  task automatic test_underrun();
    strobe(0, 0, 1'b1);
    strobe(640, 23, 1'b0);
    strobe(640, 23, 1'b0);
    checks++; if (underrun !== 1'b1) $display("[TB] FAIL underrun_retrigger: got %b expected 1", underrun); else passes++;
    repeat (200) @(posedge clk);
    #1;
    strobe(0, 0, 1'b1);
    checks++; if (underrun !== 1'b1) $display("[TB] FAIL underrun_sticky: got %b expected 1", underrun); else passes++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (underrun !== 1'b0) $display("[TB] FAIL underrun_cleared: got %b expected 0", underrun); else passes++;
    strobe(0, 0, 1'b1);
    strobe(640, 23, 1'b0);
    strobe(0, 24, 1'b1);
    checks++; if (underrun !== 1'b1) $display("[TB] FAIL underrun_late_line: got %b expected 1", underrun); else passes++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_scanline();
    for (int a = 0; a < 23040; a++) fbMem[a] = 12'hEEE;
    strobe(0, 0, 1'b1);
    runLine(23);
    strobe(80, 24, 1'b1);
    checks++; if ({vgaR, vgaG, vgaB} !== 12'hEEE) $display("[TB] FAIL scan_line24: got %h expected EEE", {vgaR, vgaG, vgaB}); else passes++;
    runLine(24);
    runLine(25);
    strobe(80, 26, 1'b1);
    checks++; if ({vgaR, vgaG, vgaB} !== LINE26) $display("[TB] FAIL scan_line26_x80: got %h expected %h", {vgaR, vgaG, vgaB}, LINE26); else passes++;
    strobe(81, 26, 1'b1);
    checks++; if ({vgaR, vgaG, vgaB} !== LINE26) $display("[TB] FAIL scan_line26_x81: got %h expected %h", {vgaR, vgaG, vgaB}, LINE26); else passes++;
    runLine(26);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_frame();
    test_border();
    test_reset_mid_fetch();
    test_underrun();
    test_scanline();
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
